serial_subtractor: RTL and testbench

// - Bit-serial two's-complement subtractor: diff = a - b - bin, computing one bit
//   per clock, LSB first, through a single full-subtractor cell and a borrow flop.
// - Inverse-operation counterpart of the ripple full-adder datapath. Used where area

---
 rtl/serial_subtractor.sv | 151 +++++++++++++++
 tb/tb_serial_subtractor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] diff,
   output logic         bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    a_sh_q, a_sh_d;
   logic [W-1:0]    b_sh_q, b_sh_d;
   logic [W-1:0]    diff_q, diff_d;
   logic            br_q, br_d;
   logic            bout_q, bout_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            d_bit;
   logic            br_nxt;
`ifdef SERIAL_SUB_OVF_EN
   logic            ovf_q, ovf_d;
   logic            a_msb_q, a_msb_d;
   logic            b_msb_q, b_msb_d;
`endif

   // full-subtractor cell on the current LSBs and the borrow flop
   always_comb begin
      d_bit  = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
      br_nxt = (~a_sh_q[0] & b_sh_q[0])
             | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
   end

   // next-state, datapath and registered handshake outputs
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      diff_d   = diff_q;
      br_d     = br_q;
      bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d    = ovf_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = bin;
               cnt_d   = '0;
               state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
               a_msb_d = a[W-1];
               b_msb_d = b[W-1];
`endif
            end
         end
         SHIFT: begin
            diff_d = {d_bit, diff_q[W-1:1]};
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = br_nxt;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               bout_d  = br_nxt;
               state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
               ovf_d = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         diff_q      <= '0;
         br_q        <= 1'b0;
         bout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q       <= 1'b0;
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         diff_q      <= diff_d;
         br_q        <= br_d;
         bout_q      <= bout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q       <= ovf_d;
         a_msb_q     <= a_msb_d;
         b_msb_q     <= b_msb_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed table, hold/ignore/reset sequences, random sweep.
// Checks ovf only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int n_chk;
   int n_fail;
   int cyc;

   serial_subtractor #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // accept one op, check W-cycle latency and result, then drain it
   task automatic run_op(input vec_t v, input string name);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      check({name, " ready"}, {31'd0, in_ready}, 32'd1);
      a = v.a;
      b = v.b;
      bin = v.bin;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      check({name, " latency"}, n, W);
      check({name, " diff"}, {24'd0, diff}, {24'd0, v.diff});
      check({name, " bout"}, {31'd0, bout}, {31'd0, v.bout});
`ifdef SERIAL_SUB_OVF_EN
      check({name, " ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({name, " drained"}, {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   vec_t tbl[8];

   initial begin
      vec_t v;
      int   n;
      int   prev_t;
      logic [W:0] full;
      logic [W-1:0] hold_diff;

      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      bin = 1'b0;

      tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
      tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      tbl[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      tbl[3] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      tbl[7] = '{8'hC8, 8'h37, 1'b1, 8'h90, 1'b0, 1'b0};

      step();
      step();
      check("rst in_ready", {31'd0, in_ready}, 32'd1);
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst diff", {24'd0, diff}, 32'd0);
      check("rst bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst ovf", {31'd0, ovf}, 32'd0);
`endif
      rst = 1'b0;
      step();

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i], $sformatf("vec%0d", i));
      end

      // hold in DONE with out_ready low; in_valid pulses must be ignored
      a = 8'h3C;
      b = 8'h0F;
      bin = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      a = 8'hAA;
      b = 8'h11;
      in_valid = 1'b1;
      check("shift in_ready", {31'd0, in_ready}, 32'd0);
      step();
      in_valid = 1'b0;
      n = 3;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      check("hold latency", n, W);
      hold_diff = diff;
      check("hold diff", {24'd0, diff}, 32'h2D);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i == 2);
         a = 8'h55;
         step();
         check("hold valid", {30'd0, out_valid, in_ready}, 32'd2);
         check("hold stable", {24'd0, diff}, {24'd0, hold_diff});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("hold drain", {30'd0, out_valid, in_ready}, 32'd1);
      check("idle keeps diff", {24'd0, diff}, 32'h2D);
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      check("no ghost op", {30'd0, out_valid, in_ready}, 32'd1);

      // asynchronous reset during SHIFT cycle 4
      a = 8'hF0;
      b = 8'h0F;
      bin = 1'b1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      step();
      rst = 1'b1;
      #1;
      check("arst diff", {24'd0, diff}, 32'd0);
      check("arst bout", {31'd0, bout}, 32'd0);
      check("arst hs", {30'd0, out_valid, in_ready}, 32'd1);
      #1;
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < W + 2; i++) begin
         step();
         if (out_valid) n++;
      end
      check("arst no valid", n, 0);
      v = '{8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0};
      run_op(v, "post rst");

      // back-to-back random sweep with out_ready held high
      out_ready = 1'b1;
      prev_t = 0;
      for (int i = 0; i < 1500; i++) begin
         if (i < 4) begin
            a = (i[0]) ? 8'hFF : 8'h00;
            b = (i[1]) ? 8'hFF : 8'h00;
         end else begin
            a = 8'($urandom);
            b = 8'($urandom);
         end
         bin = 1'($urandom);
         full = {1'b0, a} - {1'b0, b} - {8'd0, bin};
         v.a = a;
         v.b = b;
         v.diff = full[W-1:0];
         v.bout = full[W];
         v.ovf = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
         in_valid = 1'b1;
         n = 0;
         while (!in_ready && n < 50) begin
            step();
            n++;
         end
         step();
         if (i > 0) check("sweep spacing", cyc - prev_t, W + 2);
         prev_t = cyc;
         n = 0;
         while (!out_valid && n < 50) begin
            step();
            n++;
         end
         check("sweep latency", n, W);
         check("sweep diff", {24'd0, diff}, {24'd0, v.diff});
         check("sweep bout", {31'd0, bout}, {31'd0, v.bout});
`ifdef SERIAL_SUB_OVF_EN
         check("sweep ovf", {31'd0, ovf}, {31'd0, v.ovf});
`endif
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
